// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for the multicycle (non-pipelined) RV32I core. Steps the shared
// ALU, the unified instruction/data memory port and register write-back
// through fetch, decode, execute, memory and write-back states. Memory states
// wait on a request/ready handshake and fall into a sticky FAULT state if the
// memory stalls for MEM_TIMEOUT consecutive cycles.
//
// Ports:
//   clk        core clock, rising edge
//   rst        asynchronous active-high reset
//   op         opcode field of the instruction register
//   zero       ALU zero flag (branch condition)
//   mem_ready  memory completes the current request this cycle
//   pc_write   PC load enable
//   adr_src    memory address select: 0=PC, 1=ALUOut
//   mem_req    memory access request
//   mem_write  memory write strobe, valid with mem_req
//   ir_write   instruction register / OldPC load enable
//   result_src result mux: 00=ALUOut, 01=Data, 10=ALUResult
//   alu_src_a  ALU A select: 00=PC, 01=OldPC, 10=rs1
//   alu_src_b  ALU B select: 00=rs2, 01=ImmExt, 10=const 4
//   alu_op     ALU decoder class: 00=add, 01=sub, 10=funct-decoded
//   reg_write  register file write enable
//   imm_src    immediate format select, decoded from op in every state
//   state      current state encoding, for debug
//   fault      sticky fault indicator
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_req,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic [1:0] imm_src,
   output logic [3:0] state,
   output logic       fault
);

   // RV32I base opcodes
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R_TYPE = 7'b0110011;
   localparam logic [6:0] OP_BEQ    = 7'b1100011;
   localparam logic [6:0] OP_I_TYPE = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   // Wait count at which a still-stalled memory is declared dead
   localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10,
      S_FAULT    = 4'd11
   } state_t;

   // Registered Moore controls. The FETCH and BEQ flags let pc_write and
   // ir_write be gated by the live mem_ready/zero inputs after the flop.
   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_write;
      logic       pc_write_fixed;
      logic       in_fetch;
      logic       in_beq;
      logic       fault;
   } ctrl_t;

   state_t     cur_state;
   state_t     nxt_state;
   logic [7:0] wait_cnt;
   ctrl_t      ctrl_q;
   logic       mem_state;

   // Moore control values for a given state; anything not set stays 0
   function automatic ctrl_t decode_ctrl(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_req    = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
            c.in_fetch   = 1'b1;
         end
         S_DECODE: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            c.mem_req = 1'b1;
            c.adr_src = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.mem_req   = 1'b1;
            c.mem_write = 1'b1;
            c.adr_src   = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            c.reg_write = 1'b1;
         end
         S_EXECI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_op    = 2'b10;
         end
         S_JAL: begin
            c.alu_src_a      = 2'b01;
            c.alu_src_b      = 2'b10;
            c.pc_write_fixed = 1'b1;
         end
         S_BEQ: begin
            c.alu_src_a = 2'b10;
            c.alu_op    = 2'b01;
            c.in_beq    = 1'b1;
         end
         S_FAULT: begin
            c.fault = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // States that hold a memory request and therefore wait on mem_ready
   assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MEMREAD) ||
                      (cur_state == S_MEMWRITE);

   // Next-state logic. Memory states hold until mem_ready, unless the wait
   // counter has run out, in which case the stall is treated as a fault.
   // A ready in the final allowed cycle still completes normally.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         S_FETCH: begin
            if (mem_ready)                    nxt_state = S_DECODE;
            else if (wait_cnt == WAIT_LIMIT)  nxt_state = S_FAULT;
         end
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: nxt_state = S_MEMADR;
               OP_R_TYPE:    nxt_state = S_EXECR;
               OP_I_TYPE:    nxt_state = S_EXECI;
               OP_JAL:       nxt_state = S_JAL;
               OP_BEQ:       nxt_state = S_BEQ;
               default:      nxt_state = S_FAULT;
            endcase
         end
         S_MEMADR:   nxt_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (mem_ready)                    nxt_state = S_MEMWB;
            else if (wait_cnt == WAIT_LIMIT)  nxt_state = S_FAULT;
         end
         S_MEMWB:    nxt_state = S_FETCH;
         S_MEMWRITE: begin
            if (mem_ready)                    nxt_state = S_FETCH;
            else if (wait_cnt == WAIT_LIMIT)  nxt_state = S_FAULT;
         end
         S_EXECR:    nxt_state = S_ALUWB;
         S_EXECI:    nxt_state = S_ALUWB;
         S_ALUWB:    nxt_state = S_FETCH;
         S_JAL:      nxt_state = S_ALUWB;
         S_BEQ:      nxt_state = S_FETCH;
         S_FAULT:    nxt_state = S_FAULT;
         default:    nxt_state = S_FAULT;
      endcase
   end

   // State, wait counter and registered controls. The controls are decoded
   // from the next state so they line up with the state they belong to.
   // The wait counter restarts on any state change or completed handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_state <= S_FETCH;
         wait_cnt  <= 8'd0;
         ctrl_q    <= decode_ctrl(S_FETCH);
      end else begin
         cur_state <= nxt_state;
         ctrl_q    <= decode_ctrl(nxt_state);
         if ((nxt_state != cur_state) || mem_ready || !mem_state)
            wait_cnt <= 8'd0;
         else
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Immediate format depends only on the opcode, whatever the state
   always_comb begin
      case (op)
         OP_SW:   imm_src = 2'b01;
         OP_BEQ:  imm_src = 2'b10;
         OP_JAL:  imm_src = 2'b11;
         default: imm_src = 2'b00;
      endcase
   end

   // Fetch completes (and the PC advances) only on the cycle memory answers;
   // a branch updates the PC only when the comparison came out equal.
   assign pc_write   = ctrl_q.pc_write_fixed | (ctrl_q.in_fetch & mem_ready) |
                       (ctrl_q.in_beq & zero);
   assign ir_write   = ctrl_q.in_fetch & mem_ready;
   assign adr_src    = ctrl_q.adr_src;
   assign mem_req    = ctrl_q.mem_req;
   assign mem_write  = ctrl_q.mem_write;
   assign result_src = ctrl_q.result_src;
   assign alu_src_a  = ctrl_q.alu_src_a;
   assign alu_src_b  = ctrl_q.alu_src_b;
   assign alu_op     = ctrl_q.alu_op;
   assign reg_write  = ctrl_q.reg_write;
   assign fault      = ctrl_q.fault;
   assign state      = cur_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Self-checking bench for multicycle_ctrl. A behavioural model tracks each
// instruction as a queue of remaining phases chosen at decode, plus a count
// of consecutive memory stalls, and predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

   localparam int T = 16;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] BEQ = 7'b1100011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] JAL = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [6:0] op = 7'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       pc_write, adr_src, mem_req, mem_write, ir_write, reg_write, fault;
   logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
   logic [3:0] state;

   int vectors = 0;
   int miscompares = 0;

   int m_state = 0;
   int m_wait = 0;
   int m_queue[$];

   multicycle_ctrl #(.MEM_TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .adr_src(adr_src), .mem_req(mem_req),
      .mem_write(mem_write), .ir_write(ir_write), .result_src(result_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .reg_write(reg_write), .imm_src(imm_src), .state(state), .fault(fault)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Safety net so the run cannot hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Expected outputs for the model state and the current inputs
   function automatic logic [20:0] expOut();
      logic pcw, adr, req, wr, irw, rw, flt;
      logic [1:0] rs, a, b, aop, imm;
      {pcw, adr, req, wr, irw, rw, flt} = '0;
      {rs, a, b, aop} = '0;
      case (m_state)
         0:  begin req = 1; b = 2; rs = 2; irw = mem_ready; pcw = mem_ready; end
         1:  begin a = 1; b = 1; end
         2:  begin a = 2; b = 1; end
         3:  begin req = 1; adr = 1; end
         4:  begin rs = 1; rw = 1; end
         5:  begin req = 1; wr = 1; adr = 1; end
         6:  begin a = 2; aop = 2; end
         7:  begin rw = 1; end
         8:  begin a = 2; b = 1; aop = 2; end
         9:  begin a = 1; b = 2; pcw = 1; end
         10: begin a = 2; aop = 1; pcw = zero; end
         default: flt = 1;
      endcase
      if (op == SW)       imm = 2'b01;
      else if (op == BEQ) imm = 2'b10;
      else if (op == JAL) imm = 2'b11;
      else                imm = 2'b00;
      return {pcw, adr, req, wr, irw, rs, a, b, aop, rw, imm, 4'(m_state), flt};
   endfunction

   // Move the model to the next phase of the current instruction
   function automatic void advance();
      if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
         m_queue.delete();
         case (op)
            LW:      m_queue = '{2, 3, 4};
            SW:      m_queue = '{2, 5};
            RT:      m_queue = '{6, 7};
            IT:      m_queue = '{8, 7};
            JAL:     m_queue = '{9, 7};
            BEQ:     m_queue = '{10};
            default: m_queue = '{11};
         endcase
         m_state = m_queue.pop_front();
      end else if (m_queue.size() > 0) m_state = m_queue.pop_front();
      else m_state = 0;
   endfunction

   // One clock edge of the model
   function automatic void modelStep();
      if (m_state == 0 || m_state == 3 || m_state == 5) begin
         if (mem_ready) begin
            m_wait = 0;
            advance();
         end else if (m_wait == T - 1) begin
            m_wait = 0;
            m_queue.delete();
            m_state = 11;
         end else m_wait++;
      end else begin
         m_wait = 0;
         if (m_state != 11) advance();
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkAll();
      checkOutput("outputs", 32'({pc_write, adr_src, mem_req, mem_write, ir_write,
                  result_src, alu_src_a, alu_src_b, alu_op, reg_write, imm_src,
                  state, fault}), 32'(expOut()));
   endtask

   // One cycle: drive at negedge, check, then model follows the rising edge
   task automatic applyStimulus(input logic [6:0] o, input logic z, input logic r);
      @(negedge clk);
      rst = 1'b0;
      op = o;
      zero = z;
      mem_ready = r;
      #1;
      checkAll();
      @(posedge clk);
      modelStep();
   endtask

   // Asserted mid-cycle so the asynchronous return to FETCH is observed
   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      m_state = 0;
      m_wait = 0;
      m_queue.delete();
      #1;
      checkAll();
      checkOutput("reset_state", 32'(state), 32'd0);
      @(posedge clk);
   endtask

   task automatic expectState(input int v);
      #1;
      checkOutput("state_seq", 32'(state), 32'(v));
   endtask

   logic [6:0] validOps [6] = '{LW, SW, RT, IT, JAL, BEQ};

   initial begin
      logic [6:0] curOp;
      int faultCycles;

      applyReset();
      checkOutput("reset_fault", 32'(fault), 32'd0);
      checkOutput("reset_mem_req", 32'(mem_req), 32'd1);

      // R-type: 0,1,6,7,0
      applyStimulus(RT, 0, 1); expectState(1);
      applyStimulus(RT, 0, 1); expectState(6);
      applyStimulus(RT, 0, 1); expectState(7);
      #1 checkOutput("rt_reg_write", 32'(reg_write), 32'd1);
      applyStimulus(RT, 0, 1); expectState(0);

      // LW with three stall cycles in FETCH and in MEMREAD
      repeat (3) begin applyStimulus(LW, 0, 0); expectState(0); end
      applyStimulus(LW, 0, 1); expectState(1);
      applyStimulus(LW, 0, 1); expectState(2);
      applyStimulus(LW, 0, 1); expectState(3);
      repeat (3) begin applyStimulus(LW, 0, 0); expectState(3); end
      applyStimulus(LW, 0, 1); expectState(4);
      #1 checkOutput("lw_result_src", 32'(result_src), 32'd1);
      applyStimulus(LW, 0, 1); expectState(0);

      // BEQ taken then not taken
      applyStimulus(BEQ, 1, 1); applyStimulus(BEQ, 1, 1); expectState(10);
      #1 checkOutput("beq_taken_pcw", 32'(pc_write), 32'd1);
      checkOutput("beq_alu_op", 32'(alu_op), 32'd1);
      applyStimulus(BEQ, 1, 1); expectState(0);
      applyStimulus(BEQ, 0, 1); applyStimulus(BEQ, 0, 1); expectState(10);
      #1 checkOutput("beq_not_taken_pcw", 32'(pc_write), 32'd0);
      applyStimulus(BEQ, 0, 1); expectState(0);

      // JAL: 0,1,9,7,0
      applyStimulus(JAL, 0, 1); expectState(1);
      applyStimulus(JAL, 0, 1); expectState(9);
      #1 checkOutput("jal_imm_src", 32'(imm_src), 32'd3);
      checkOutput("jal_pc_write", 32'(pc_write), 32'd1);
      applyStimulus(JAL, 0, 1); expectState(7);
      applyStimulus(JAL, 0, 1); expectState(0);

      // Illegal opcode: sticky fault until reset
      applyStimulus(BAD, 0, 1); expectState(1);
      applyStimulus(BAD, 0, 1); expectState(11);
      repeat (5) applyStimulus(BAD, 0, 1);
      #1 checkOutput("fault_sticky", 32'(fault), 32'd1);
      applyReset();
      checkOutput("fault_cleared", 32'(fault), 32'd0);

      // SW timeout: fault after exactly T stall cycles
      applyStimulus(SW, 0, 1); applyStimulus(SW, 0, 1); applyStimulus(SW, 0, 1);
      expectState(5);
      repeat (T - 1) applyStimulus(SW, 0, 0);
      expectState(5);
      applyStimulus(SW, 0, 0); expectState(11);
      applyReset();

      // Same, but memory answers on the last allowed cycle
      applyStimulus(SW, 0, 1); applyStimulus(SW, 0, 1); applyStimulus(SW, 0, 1);
      repeat (T - 1) applyStimulus(SW, 0, 0);
      applyStimulus(SW, 0, 1); expectState(0);

      // Reset in the middle of a handshake
      applyStimulus(SW, 0, 1); applyStimulus(SW, 0, 1); applyStimulus(SW, 0, 1);
      applyStimulus(SW, 0, 0); applyStimulus(SW, 0, 0);
      applyReset();
      applyStimulus(SW, 0, 0); expectState(0);
      #1 checkOutput("post_reset_mem_req", 32'(mem_req), 32'd1);

      // Randomized traffic against the model
      curOp = RT;
      faultCycles = 0;
      for (int i = 0; i < 2000; i++) begin
         if (m_state == 0) begin
            if ($urandom_range(0, 9) == 0) curOp = 7'($urandom_range(0, 127));
            else curOp = validOps[$urandom_range(0, 5)];
         end
         if (m_state == 11) faultCycles++;
         else faultCycles = 0;
         if (faultCycles > 3 || $urandom_range(0, 199) == 0) applyReset();
         else applyStimulus(curOp, 1'($urandom_range(0, 1)),
                            ($urandom_range(0, 3) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
